// File: rtl/uart_rx_core.sv
// UART receive engine: synchronised, oversampled, majority-voted frame decoder
// with parity/stop checking, break detection and a ready/valid holding register.
module uart_rx_core #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 uart_rx,
  output logic                 rx_out_valid,
  input  logic                 rx_out_ready,
  output logic [DATA_BITS-1:0] rx_out_data,
  output logic                 rx_out_parity_err,
  output logic                 rx_out_frame_err,
  output logic                 rx_break,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int TCW = $clog2(OVERSAMPLE);
  localparam int BCW = 4;

  localparam logic [TCW-1:0] TC_LAST = TCW'(OVERSAMPLE - 1);
  localparam logic [TCW-1:0] TC_PRE  = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [TCW-1:0] TC_MID  = TCW'(OVERSAMPLE / 2);
  localparam logic [TCW-1:0] TC_POST = TCW'(OVERSAMPLE / 2 + 1);

  localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);
  localparam logic           ODD       = (PARITY_ODD != 0);
  localparam logic           HAS_PAR   = (PARITY_EN != 0);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [2:0]             r_state;
  logic [TCW-1:0]         r_tc;
  logic [BCW-1:0]         r_bcnt;
  logic                   r_s0;
  logic                   r_s1;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_perr;
  logic                   r_ferr;
  logic                   r_zero;
  logic                   r_brk;
  logic                   r_done;

  logic                   r_valid;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_data_perr;
  logic                   r_data_ferr;
  logic                   r_break;
  logic                   r_overrun;

  logic w_line;
  logic w_maj;
  logic w_at_post;
  logic w_at_last;
  logic w_accept;

  // Line idles high, so the synchroniser resets to 1 to avoid a phantom start.
  always_ff @(posedge clk) begin
    if (rst) r_sync <= '1;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], uart_rx};
  end

  assign w_line    = r_sync[SYNC_STAGES-1];
  assign w_maj     = (r_s0 & r_s1) | (r_s0 & w_line) | (r_s1 & w_line);
  assign w_at_post = (r_tc == TC_POST);
  assign w_at_last = (r_tc == TC_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tc    <= '0;
      r_bcnt  <= '0;
      r_s0    <= 1'b0;
      r_s1    <= 1'b0;
      r_shift <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_zero  <= 1'b0;
      r_brk   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (baud_tick) begin
        case (r_state)
          S_IDLE: begin
            if (!w_line) begin
              r_state <= S_START;
              r_tc    <= '0;
              r_bcnt  <= '0;
              r_perr  <= 1'b0;
              r_ferr  <= 1'b0;
              r_zero  <= 1'b1;
              r_brk   <= 1'b0;
            end
          end
          S_WAIT_IDLE: begin
            if (w_line) r_state <= S_IDLE;
          end
          default: begin
            r_tc <= w_at_last ? '0 : r_tc + TCW'(1);
            if (r_tc == TC_PRE) r_s0 <= w_line;
            if (r_tc == TC_MID) r_s1 <= w_line;
            case (r_state)
              S_START: begin
                if (w_at_post && w_maj) begin
                  r_state <= S_IDLE;
                  r_tc    <= '0;
                end else if (w_at_last) begin
                  r_state <= S_DATA;
                  r_bcnt  <= '0;
                end
              end
              S_DATA: begin
                if (w_at_post) begin
                  r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
                  r_zero  <= r_zero & ~w_maj;
                end
                if (w_at_last) begin
                  if (r_bcnt == LAST_DATA) begin
                    r_bcnt  <= '0;
                    r_state <= HAS_PAR ? S_PARITY : S_STOP;
                  end else begin
                    r_bcnt <= r_bcnt + BCW'(1);
                  end
                end
              end
              S_PARITY: begin
                if (w_at_post) begin
                  r_perr <= w_maj ^ (^r_shift) ^ ODD;
                  r_zero <= r_zero & ~w_maj;
                end
                if (w_at_last) begin
                  r_state <= S_STOP;
                  r_bcnt  <= '0;
                end
              end
              S_STOP: begin
                // The frame is decided at the vote of the last stop bit, so
                // the end of that bit is never reached in this state.
                if (w_at_post) begin
                  r_ferr <= r_ferr | ~w_maj;
                  if (r_bcnt == '0) r_brk <= r_zero & ~w_maj;
                  if (r_bcnt == LAST_STOP) begin
                    r_done  <= 1'b1;
                    r_tc    <= '0;
                    r_bcnt  <= '0;
                    r_state <= w_line ? S_IDLE : S_WAIT_IDLE;
                  end
                end else if (w_at_last) begin
                  r_bcnt <= r_bcnt + BCW'(1);
                end
              end
              default: begin
                r_state <= S_IDLE;
                r_tc    <= '0;
              end
            endcase
          end
        endcase
      end
    end
  end

  // A frame may load while the old one is leaving in the same cycle.
  assign w_accept = !r_valid || rx_out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_data_perr <= 1'b0;
      r_data_ferr <= 1'b0;
      r_break     <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_break   <= r_done & r_brk;
      r_overrun <= r_done & ~w_accept;
      if (r_done && w_accept) begin
        r_valid     <= 1'b1;
        r_data      <= r_shift;
        r_data_perr <= r_perr;
        r_data_ferr <= r_ferr;
      end else if (r_valid && rx_out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_out_valid      = r_valid;
  assign rx_out_data       = r_data;
  assign rx_out_parity_err = r_data_perr;
  assign rx_out_frame_err  = r_data_ferr;
  assign rx_break          = r_break;
  assign rx_overrun        = r_overrun;
  assign rx_busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Randomised bench for uart_rx_core: three configurations (8N1, 7E1, 8N2)
// checked against a frame-level reference model.
module tb_uart_rx_core;

  localparam int OS = 16;

  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       fe;
    logic       brk;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic [2:0] rx_line = 3'b111;
  logic [2:0] rdy = 3'b111;

  logic       v0, pe0, fe0, brk0, ovr0, busy0;
  logic [7:0] d0;
  logic       v1, pe1, fe1, brk1, ovr1, busy1;
  logic [6:0] d1;
  logic       v2, pe2, fe2, brk2, ovr2, busy2;
  logic [7:0] d2;

  int checks = 0;
  int errors = 0;

  rec_t log0[$], log1[$], log2[$];
  int   brk_cnt0 = 0, brk_cnt1 = 0, brk_cnt2 = 0;
  int   ovr_cnt0 = 0;
  int   vcyc0 = 0;

  uart_rx_core dut0 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .uart_rx(rx_line[0]),
    .rx_out_valid(v0), .rx_out_ready(rdy[0]), .rx_out_data(d0),
    .rx_out_parity_err(pe0), .rx_out_frame_err(fe0), .rx_break(brk0),
    .rx_overrun(ovr0), .rx_busy(busy0));

  uart_rx_core #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .uart_rx(rx_line[1]),
    .rx_out_valid(v1), .rx_out_ready(rdy[1]), .rx_out_data(d1),
    .rx_out_parity_err(pe1), .rx_out_frame_err(fe1), .rx_break(brk1),
    .rx_overrun(ovr1), .rx_busy(busy1));

  uart_rx_core #(.STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .uart_rx(rx_line[2]),
    .rx_out_valid(v2), .rx_out_ready(rdy[2]), .rx_out_data(d2),
    .rx_out_parity_err(pe2), .rx_out_frame_err(fe2), .rx_break(brk2),
    .rx_overrun(ovr2), .rx_busy(busy2));

  always #5 clk = ~clk;

  // Irregular baud ticks: roughly one clock in three, with random gaps.
  initial begin
    forever begin
      @(posedge clk);
      #1 baud_tick = ($urandom_range(0, 2) == 0);
    end
  end

  always @(negedge clk) begin
    rec_t r;
    if (!rst) begin
      r.brk = 1'b0;
      if (v0 && rdy[0]) begin r.d = {1'b0, d0}; r.pe = pe0; r.fe = fe0; log0.push_back(r); end
      if (v1 && rdy[1]) begin r.d = {2'b0, d1}; r.pe = pe1; r.fe = fe1; log1.push_back(r); end
      if (v2 && rdy[2]) begin r.d = {1'b0, d2}; r.pe = pe2; r.fe = fe2; log2.push_back(r); end
      if (brk0) brk_cnt0++;
      if (brk1) brk_cnt1++;
      if (brk2) brk_cnt2++;
      if (ovr0) ovr_cnt0++;
      if (v0) vcyc0++;
    end
  end

  // Frame-level reference: what the receiver must report for the given wire bits.
  function automatic rec_t model(input int nd, input logic [8:0] d, input bit pe,
                                 input bit odd, input bit p, input int ns,
                                 input logic [1:0] st);
    rec_t r;
    logic [8:0] m;
    bit want_p;
    m = d & ((9'd1 << nd) - 9'd1);
    want_p = ($countones(m) % 2 == 1) ^ odd;
    r.d   = m;
    r.pe  = pe && (p != want_p);
    r.fe  = (st[0] == 1'b0) || (ns == 2 && st[1] == 1'b0);
    r.brk = (m == 9'd0) && (!pe || p == 1'b0) && (st[0] == 1'b0);
    return r;
  endfunction

  task automatic wait_ticks(input int n);
    int c = 0;
    while (c < n) begin
      @(posedge clk);
      if (baud_tick) c++;
    end
    #1;
  endtask

  task automatic send_frame(input int w, input int nd, input logic [8:0] d, input bit pe,
                            input bit p, input int ns, input logic [1:0] st);
    rx_line[w] = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < nd; i++) begin
      rx_line[w] = d[i];
      wait_ticks(OS);
    end
    if (pe) begin
      rx_line[w] = p;
      wait_ticks(OS);
    end
    for (int i = 0; i < ns; i++) begin
      rx_line[w] = st[i];
      wait_ticks(OS);
    end
    rx_line[w] = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if ({v0, v1, v2, busy0, busy1, busy2} !== 6'b0) begin
      errors++; $display("FAIL reset_valid_busy: got %b expected 000000", {v0, v1, v2, busy0, busy1, busy2});
    end
    checks++;
    if ({d0, pe0, fe0, brk0, ovr0} !== 12'h000) begin
      errors++; $display("FAIL reset_outputs: got %h expected 000", {d0, pe0, fe0, brk0, ovr0});
    end
    rst = 1'b0;
    wait_ticks(4);
  endtask

  task automatic test_basic;
    int n = log0.size();
    int vc = vcyc0;
    int bc = brk_cnt0;
    rdy[0] = 1'b1;
    send_frame(0, 8, 9'h0A5, 0, 0, 1, 2'b11);
    wait_ticks(2);
    checks++;
    if (log0.size() !== n + 1) begin
      errors++; $display("FAIL basic_count: got %0d expected %0d", log0.size(), n + 1);
    end else begin
      checks++;
      if ({log0[n].d, log0[n].pe, log0[n].fe} !== {9'h0A5, 2'b00}) begin
        errors++; $display("FAIL basic_frame: got d=%h pe=%b fe=%b expected d=a5 pe=0 fe=0",
                           log0[n].d, log0[n].pe, log0[n].fe);
      end
    end
    checks++;
    if (vcyc0 - vc !== 1) begin
      errors++; $display("FAIL basic_valid_cycles: got %0d expected 1", vcyc0 - vc);
    end
    checks++;
    if (busy0 !== 1'b0 || brk_cnt0 != bc) begin
      errors++; $display("FAIL basic_idle: got busy=%b breaks=%0d expected busy=0 breaks=0", busy0, brk_cnt0 - bc);
    end
  endtask

  task automatic test_false_start;
    int n = log0.size();
    int vc = vcyc0;
    rx_line[0] = 1'b0;
    wait_ticks(3);
    rx_line[0] = 1'b1;
    wait_ticks(OS + 2);
    checks++;
    if (busy0 !== 1'b0 || log0.size() != n || vcyc0 != vc) begin
      errors++; $display("FAIL false_start: got busy=%b frames=%0d valid_cycles=%0d expected 0 0 0",
                         busy0, log0.size() - n, vcyc0 - vc);
    end
  endtask

  task automatic test_parity;
    rec_t e;
    int n;
    logic [8:0] d;
    bit p;
    rdy[1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 0)      begin d = 9'h041; p = 1'b0; end
      else if (k == 1) begin d = 9'h041; p = 1'b1; end
      else             begin d = 9'($urandom_range(0, 127)); p = 1'($urandom_range(0, 1)); end
      e = model(7, d, 1, 0, p, 1, 2'b11);
      n = log1.size();
      send_frame(1, 7, d, 1, p, 1, 2'b11);
      wait_ticks(2);
      checks++;
      if (log1.size() !== n + 1) begin
        errors++; $display("FAIL parity_count[%0d]: got %0d expected %0d", k, log1.size(), n + 1);
      end else if ({log1[n].d, log1[n].pe, log1[n].fe} !== {e.d, e.pe, e.fe}) begin
        errors++; $display("FAIL parity_frame[%0d]: got d=%h pe=%b fe=%b expected d=%h pe=%b fe=%b",
                           k, log1[n].d, log1[n].pe, log1[n].fe, e.d, e.pe, e.fe);
      end
    end
  endtask

  task automatic test_stop2;
    rec_t e;
    int n, bc;
    logic [8:0] d;
    logic [1:0] st;
    rdy[2] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 0)      begin d = 9'h03C; st = 2'b01; end
      else if (k == 1) begin d = 9'h000; st = 2'b10; end
      else begin
        d  = 9'($urandom_range(0, 255));
        st = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
      end
      e  = model(8, d, 0, 0, 0, 2, st);
      n  = log2.size();
      bc = brk_cnt2;
      send_frame(2, 8, d, 0, 0, 2, st);
      wait_ticks(2);
      checks++;
      if (log2.size() !== n + 1) begin
        errors++; $display("FAIL stop2_count[%0d]: got %0d expected %0d", k, log2.size(), n + 1);
      end else if ({log2[n].d, log2[n].pe, log2[n].fe} !== {e.d, e.pe, e.fe}) begin
        errors++; $display("FAIL stop2_frame[%0d]: got d=%h pe=%b fe=%b expected d=%h pe=%b fe=%b",
                           k, log2[n].d, log2[n].pe, log2[n].fe, e.d, e.pe, e.fe);
      end
      checks++;
      if (brk_cnt2 - bc !== int'(e.brk)) begin
        errors++; $display("FAIL stop2_break[%0d]: got %0d expected %0d", k, brk_cnt2 - bc, e.brk);
      end
    end
  endtask

  task automatic test_overrun;
    int n = log0.size();
    int oc = ovr_cnt0;
    rdy[0] = 1'b0;
    send_frame(0, 8, 9'h011, 0, 0, 1, 2'b11);
    wait_ticks(2);
    send_frame(0, 8, 9'h022, 0, 0, 1, 2'b11);
    wait_ticks(2);
    checks++;
    if (v0 !== 1'b1 || d0 !== 8'h11) begin
      errors++; $display("FAIL overrun_hold: got valid=%b data=%h expected valid=1 data=11", v0, d0);
    end
    checks++;
    if (ovr_cnt0 - oc !== 1) begin
      errors++; $display("FAIL overrun_pulse: got %0d expected 1", ovr_cnt0 - oc);
    end
    rdy[0] = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (log0.size() !== n + 1 || v0 !== 1'b0) begin
      errors++; $display("FAIL overrun_transfer: got transfers=%0d valid=%b expected 1 0", log0.size() - n, v0);
    end else begin
      checks++;
      if (log0[n].d !== 9'h011) begin
        errors++; $display("FAIL overrun_data: got %h expected 011", log0[n].d);
      end
    end
  endtask

  task automatic test_break;
    int n = log0.size();
    int bc = brk_cnt0;
    rdy[0] = 1'b1;
    rx_line[0] = 1'b0;
    wait_ticks(3 * 10 * OS);
    checks++;
    if (log0.size() !== n + 1) begin
      errors++; $display("FAIL break_count: got %0d expected 1", log0.size() - n);
    end else begin
      checks++;
      if ({log0[n].d, log0[n].pe, log0[n].fe} !== {9'h000, 2'b01}) begin
        errors++; $display("FAIL break_frame: got d=%h pe=%b fe=%b expected d=000 pe=0 fe=1",
                           log0[n].d, log0[n].pe, log0[n].fe);
      end
    end
    checks++;
    if (brk_cnt0 - bc !== 1 || busy0 !== 1'b1) begin
      errors++; $display("FAIL break_pulse: got pulses=%0d busy=%b expected 1 1", brk_cnt0 - bc, busy0);
    end
    rx_line[0] = 1'b1;
    wait_ticks(4);
    checks++;
    if (busy0 !== 1'b0 || log0.size() !== n + 1) begin
      errors++; $display("FAIL break_release: got busy=%b frames=%0d expected 0 1", busy0, log0.size() - n);
    end
    send_frame(0, 8, 9'h05A, 0, 0, 1, 2'b11);
    wait_ticks(2);
    checks++;
    if (log0.size() !== n + 2) begin
      errors++; $display("FAIL break_next_count: got %0d expected 2", log0.size() - n);
    end else if ({log0[n+1].d, log0[n+1].pe, log0[n+1].fe} !== {9'h05A, 2'b00} || brk_cnt0 - bc != 1) begin
      errors++; $display("FAIL break_next_frame: got d=%h fe=%b breaks=%0d expected d=05a fe=0 breaks=1",
                         log0[n+1].d, log0[n+1].fe, brk_cnt0 - bc);
    end
  endtask

  task automatic test_back_to_back;
    rec_t exp_q[$];
    logic [8:0] d;
    int n = log0.size();
    rdy[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      d = 9'($urandom_range(0, 255));
      exp_q.push_back(model(8, d, 0, 0, 0, 1, 2'b11));
      send_frame(0, 8, d, 0, 0, 1, 2'b11);
    end
    wait_ticks(2);
    checks++;
    if (log0.size() !== n + 8) begin
      errors++; $display("FAIL b2b_count: got %0d expected 8", log0.size() - n);
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if ({log0[n+k].d, log0[n+k].pe, log0[n+k].fe} !== {exp_q[k].d, exp_q[k].pe, exp_q[k].fe}) begin
          errors++; $display("FAIL b2b_frame[%0d]: got d=%h fe=%b expected d=%h fe=%b",
                             k, log0[n+k].d, log0[n+k].fe, exp_q[k].d, exp_q[k].fe);
        end
      end
    end
  endtask

  task automatic test_reset_midframe;
    int n;
    rdy[0] = 1'b0;
    send_frame(0, 8, 9'h077, 0, 0, 1, 2'b11);
    wait_ticks(2);
    checks++;
    if (v0 !== 1'b1) begin
      errors++; $display("FAIL midreset_prefill: got valid=%b expected 1", v0);
    end
    rx_line[0] = 1'b0;
    wait_ticks(3 * OS);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rx_line[0] = 1'b1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (v0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++; $display("FAIL midreset_clear: got valid=%b busy=%b expected 0 0", v0, busy0);
    end
    n = log0.size();
    rdy[0] = 1'b1;
    wait_ticks(12 * OS);
    checks++;
    if (log0.size() !== n || v0 !== 1'b0) begin
      errors++; $display("FAIL midreset_discard: got frames=%0d valid=%b expected 0 0", log0.size() - n, v0);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_false_start;
    test_parity;
    test_stop2;
    test_overrun;
    test_break;
    test_back_to_back;
    test_reset_midframe;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Parametrised UART receiver that replaces the fixed 8N1 receive engine. It supports 5-9 data bits, optional even/odd parity, 1 or 2 stop bits, configurable oversampling, majority-vote sampling, and error and break detection. It sits between the async RX pin and the RX FIFO adapter/MMIO. It shares the baud tick generator with the TX path and exposes one ready/valid output holding register.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9
OVERSAMPLE, 16, baud_tick pulses per bit period, even, legal 8..32
PARITY_EN, 0, 1 = parity bit present after data
PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0
STOP_BITS, 1, stop bits checked, legal 1 or 2
SYNC_STAGES, 2, flops in the uart_rx synchroniser, legal 2..3

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
baud_tick  in  1  1-cycle pulse at OVERSAMPLE x baud
uart_rx  in  1  async serial input, idle high
rx_out_valid  out  1  holding register contains a frame
rx_out_ready  in  1  consumer accepts the frame
rx_out_data  out  DATA_BITS  received data, LSB = first bit on the wire
rx_out_parity_err  out  1  parity mismatch for the held frame
rx_out_frame_err  out  1  a stop bit sampled 0 for the held frame
rx_break  out  1  1-cycle pulse: break condition detected
rx_overrun  out  1  1-cycle pulse: completed frame dropped because the holding register was full
rx_busy  out  1  high in any state except IDLE

Behaviour:
- Single clock; synchronous active-high reset, as already decided.
- Reset values: all synchroniser flops = 1; state = IDLE; all counters = 0; all outputs = 0.
- Reset asserted mid-frame: return to IDLE and discard the frame. Reset also clears the holding register.
- Sampling:
  - Tick counter tc counts baud_tick from 0 to OVERSAMPLE-1 within each bit; M = OVERSAMPLE/2.
  - The bit value is the majority of the synchronised line at ticks M-1, M and M+1.
  - The state advances on the tick where tc = OVERSAMPLE-1, except where noted below.
- States:
  - IDLE: when the synchronised line = 0 on a baud_tick, set tc=0 and go to START.
  - START: at tc=M+1, a majority of 1 is a false start → IDLE with no output. Otherwise go to DATA at the end of the bit.
  - DATA: shift each sampled bit in LSB-first. After DATA_BITS bits, go to PARITY if PARITY_EN, else STOP.
  - PARITY: compare the sampled bit with the XOR of the data (inverted when PARITY_ODD). Store the mismatch flag.
  - STOP:
    - Any stop bit majority of 0 sets frame_err.
    - Decision point is the majority sample (tc=M+1) of the final stop bit, not the end of the bit.
    - At that point: deliver the frame, then go to IDLE if the line is 1, else WAIT_IDLE.
  - WAIT_IDLE: hold until the synchronised line = 1 on a baud_tick, then go to IDLE. This prevents a held-low line from retriggering a start.
- Break: all data bits = 0, parity bit (if present) = 0, and first stop bit = 0 → pulse rx_break at delivery. The frame is still delivered with frame_err=1.
- Delivery happens in the cycle after the final stop decision:
  - If the holding register is empty, or is being transferred this same cycle (valid & ready), load data, parity_err and frame_err, and set rx_out_valid=1. No overrun.
  - Otherwise keep the old contents, drop the new frame, and pulse rx_overrun for 1 cycle.
- Handshake:
  - Transfer occurs when valid & ready.
  - rx_out_valid stays high and data/flags stay stable until transfer; valid deasserts the cycle after transfer unless a new load coincides.
  - rx_out_ready is ignored while valid=0.
- Latency: rx_out_valid rises 1 clk after the baud_tick carrying the final stop-bit majority sample.
- baud_tick high while in reset is ignored. A missing baud_tick simply stalls all counters.

Test Plan:
- Defaults (8N1, OVERSAMPLE=16): send 0xA5 with rx_out_ready=1 → valid for 1 cycle, data=0xA5, both error flags 0, rx_busy low afterwards.
- DATA_BITS=7, PARITY_EN=1, PARITY_ODD=0: send 0x41 with a correct parity bit of 0 → parity_err=0. Send 0x41 with parity bit 1 → parity_err=1, data=0x41.
- Defaults: a 3-tick low glitch on the idle line → START aborts, no valid, rx_busy returns to 0 within 1 bit time.
- Defaults, rx_out_ready=0: send 0x11 then 0x22 → data stays 0x11, one rx_overrun pulse at the 0x22 delivery. Raise ready → 0x11 transfers, valid falls.
- STOP_BITS=2: send 0x3C with the second stop bit = 0 → frame_err=1, data=0x3C.
- Defaults: hold the line low for 3 frame times, then release → exactly one frame with data=0x00 and frame_err=1, one rx_break pulse, and no further frames until the line goes high. A following 0x5A is received cleanly.
